// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the register-file read stage and the
// iterative RV32M multiply/divide unit.
interface muldiv_unit_if #(
    parameter int Width = 32
);
    logic             start;
    logic [2:0]       funct3;
    logic [Width-1:0] OpA;
    logic [Width-1:0] OpB;
    logic [4:0]       RdIn;
    logic             busy;
    logic             done;
    logic [Width-1:0] Result;
    logic [4:0]       RdOut;

    modport master (
        output start, funct3, OpA, OpB, RdIn,
        input  busy, done, Result, RdOut
    );

    modport slave (
        input  start, funct3, OpA, OpB, RdIn,
        output busy, done, Result, RdOut
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: magnitude shift-add multiply and
// restoring divide over Width cycles, sign fix-up and special cases in FIX.
module muldiv_unit #(
    parameter int Width = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(Width + 1);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;
    localparam logic [CW-1:0]    CNT_LAST = CW'(Width - 1);
    localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [Width-1:0] ZERO     = {Width{1'b0}};
    localparam logic [Width-1:0] ONES     = {Width{1'b1}};
    localparam logic [Width-1:0] ONE      = {{(Width-1){1'b0}}, 1'b1};
    localparam logic [Width-1:0] MIN_NEG  = {1'b1, {(Width-1){1'b0}}};

    logic [1:0]         state_r;
    logic [CW-1:0]      cnt_r;
    logic [2:0]         funct3_r;
    logic [4:0]         rd_r;
    logic               neg_a_r;
    logic               neg_b_r;
    logic [Width-1:0]   a_mag_r;
    logic [Width-1:0]   b_mag_r;
    logic [Width-1:0]   a_orig_r;
    logic [2*Width-1:0] prod_r;
    logic [Width:0]     rem_r;
    logic [Width-1:0]   quo_r;
    logic [Width-1:0]   result_r;
    logic [4:0]         rdout_r;
    logic               busy_r;
    logic               done_r;

    logic               neg_a_s;
    logic               neg_b_s;
    logic [Width-1:0]   a_mag_s;
    logic [Width-1:0]   b_mag_s;
    logic [Width:0]     add_s;
    logic [Width:0]     rem_sh_s;
    logic [Width+1:0]   trial_s;
    logic [2*Width-1:0] prod_fix_s;
    logic [Width-1:0]   quo_fix_s;
    logic [Width-1:0]   rem_fix_s;
    logic               div_zero_s;
    logic               ovf_s;
    logic [Width-1:0]   fix_res_s;

    // Operand signedness and magnitudes at capture; MUL is treated as unsigned (low word is identical)
    always_comb begin
        neg_a_s = 1'b0;
        neg_b_s = 1'b0;
        case (bus.funct3)
            3'b001, 3'b100, 3'b110: begin
                neg_a_s = bus.OpA[Width-1];
                neg_b_s = bus.OpB[Width-1];
            end
            3'b010:  neg_a_s = bus.OpA[Width-1];
            default: begin
                neg_a_s = 1'b0;
                neg_b_s = 1'b0;
            end
        endcase
        a_mag_s = neg_a_s ? -bus.OpA : bus.OpA;
        b_mag_s = neg_b_s ? -bus.OpB : bus.OpB;
    end

    // One shift-add multiply step and one restoring divide step per CALC cycle
    always_comb begin
        add_s    = {1'b0, prod_r[2*Width-1:Width]} + (prod_r[0] ? {1'b0, a_mag_r} : {(Width+1){1'b0}});
        rem_sh_s = {rem_r[Width-1:0], quo_r[Width-1]};
        trial_s  = {1'b0, rem_sh_s} - {2'b00, b_mag_r};
    end

    // Sign correction and special-case selection of the final result
    always_comb begin
        prod_fix_s = (neg_a_r ^ neg_b_r) ? -prod_r : prod_r;
        quo_fix_s  = (neg_a_r ^ neg_b_r) ? -quo_r : quo_r;
        rem_fix_s  = neg_a_r ? -rem_r[Width-1:0] : rem_r[Width-1:0];
        div_zero_s = (b_mag_r == ZERO);
        ovf_s      = neg_a_r & neg_b_r & (a_mag_r == MIN_NEG) & (b_mag_r == ONE);
        fix_res_s  = ZERO;
        case (funct3_r)
            3'b000:                 fix_res_s = prod_fix_s[Width-1:0];
            3'b001, 3'b010, 3'b011: fix_res_s = prod_fix_s[2*Width-1:Width];
            3'b100, 3'b101: begin
                if (div_zero_s) begin
                    fix_res_s = ONES;
                end else if (ovf_s) begin
                    fix_res_s = MIN_NEG;
                end else begin
                    fix_res_s = quo_fix_s;
                end
            end
            3'b110, 3'b111: begin
                if (div_zero_s) begin
                    fix_res_s = a_orig_r;
                end else if (ovf_s) begin
                    fix_res_s = ZERO;
                end else begin
                    fix_res_s = rem_fix_s;
                end
            end
            default: fix_res_s = ZERO;
        endcase
    end

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= {CW{1'b0}};
            funct3_r <= 3'b000;
            rd_r     <= 5'd0;
            neg_a_r  <= 1'b0;
            neg_b_r  <= 1'b0;
            a_mag_r  <= ZERO;
            b_mag_r  <= ZERO;
            a_orig_r <= ZERO;
            prod_r   <= {(2*Width){1'b0}};
            rem_r    <= {(Width+1){1'b0}};
            quo_r    <= ZERO;
            result_r <= ZERO;
            rdout_r  <= 5'd0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        funct3_r <= bus.funct3;
                        rd_r     <= bus.RdIn;
                        neg_a_r  <= neg_a_s;
                        neg_b_r  <= neg_b_s;
                        a_mag_r  <= a_mag_s;
                        b_mag_r  <= b_mag_s;
                        a_orig_r <= bus.OpA;
                        prod_r   <= {ZERO, b_mag_s};
                        quo_r    <= a_mag_s;
                        rem_r    <= {(Width+1){1'b0}};
                        cnt_r    <= {CW{1'b0}};
                        busy_r   <= 1'b1;
                        state_r  <= CALC;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                CALC: begin
                    // Multiplier bits shift out of the low half as the partial sum shifts in
                    prod_r <= {add_s, prod_r[Width-1:1]};
                    quo_r  <= {quo_r[Width-2:0], ~trial_s[Width+1]};
                    rem_r  <= trial_s[Width+1] ? rem_sh_s : trial_s[Width:0];
                    cnt_r  <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= FIX;
                    end
                end
                FIX: begin
                    result_r <= fix_res_s;
                    rdout_r  <= rd_r;
                    done_r   <= 1'b1;
                    state_r  <= DONE;
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.Result = result_r;
    assign bus.RdOut  = rdout_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed test-plan cases plus random ops
// checked against a plain-arithmetic RV32M reference model.
module tb_muldiv_unit;
    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   passes;
    logic prev_done;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    muldiv_unit_if #(.Width(32)) bus ();
    muldiv_unit #(.Width(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (f)
            3'd0: begin r = ua * ub; return r[31:0]; end
            3'd1: begin r = sa * sb; return r[63:32]; end
            3'd2: begin r = sa * ub; return r[63:32]; end
            3'd3: begin r = ua * ub; return r[63:32]; end
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                r = sa / sb; return r[31:0];
            end
            3'd5: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                r = ua / ub; return r[31:0];
            end
            3'd6: begin
                if (b == 32'h0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                r = sa % sb; return r[31:0];
            end
            default: begin
                if (b == 32'h0) return a;
                r = ua % ub; return r[31:0];
            end
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return 32'h0 - 32'($urandom_range(1, 20));
            default: return $urandom();
        endcase
    endfunction

    // Waits for idle, presents one request for a single edge, then scrambles the operands
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("issue_timeout", 32'(bus.busy), 32'h0);
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.OpA    = a;
        bus.OpB    = b;
        bus.RdIn   = rd;
        exp_q.push_back('{res: ref_model(f, a, b), rd: rd, cyc: cyc + 34});
        @(negedge clk);
        bus.start  = 1'b0;
        bus.funct3 = 3'($urandom());
        bus.OpA    = $urandom();
        bus.OpB    = $urandom();
        bus.RdIn   = 5'($urandom());
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(exp_q.size()), 32'h0);
    endtask

    // Monitor: every done pulse pops one expectation and checks value, index, latency and pulse width
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            chk("done_pulse_width", 32'(prev_done), 32'h0);
            if (exp_q.size() == 0) begin
                chk("spurious_done", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("result", bus.Result, e.res);
                chk("rdout", 32'(bus.RdOut), 32'(e.rd));
                chk("latency", 32'(cyc), 32'(e.cyc));
            end
        end
        prev_done <= bus.done;
    end

    logic [2:0]  d_f [14] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] d_a [14] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9, 32'd9};
    logic [31:0] d_b [14] = '{32'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2, 32'd2,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};

    initial begin
        int n;
        cyc = 0; checks = 0; passes = 0; prev_done = 1'b0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.funct3 = 3'd0; bus.OpA = 32'h0; bus.OpB = 32'h0; bus.RdIn = 5'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        chk("reset_done", 32'(bus.done), 32'h0);
        chk("reset_result", bus.Result, 32'h0);
        chk("reset_rdout", 32'(bus.RdOut), 32'h0);
        rst_n = 1'b1;

        // MUL 7x6: value, latency and busy window
        issue(3'd0, 32'd7, 32'd6, 5'd5);
        n = bus.busy ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.busy) n++;
            else break;
        end
        chk("busy_cycles", 32'(n), 32'd34);
        drain("drain_mul");

        for (int i = 0; i < 14; i++) issue(d_f[i], d_a[i], d_b[i], 5'(i + 1));
        drain("drain_directed");

        // A start pulse mid-operation must be ignored entirely
        issue(3'd0, 32'd3, 32'd4, 5'd7);
        repeat (8) @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd0; bus.OpA = 32'd9; bus.OpB = 32'd9; bus.RdIn = 5'd9;
        @(negedge clk);
        bus.start = 1'b0;
        drain("drain_handshake");
        repeat (50) @(negedge clk);

        // Reset in the middle of a divide discards it
        issue(3'd4, 32'd1000, 32'd7, 5'd3);
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(bus.busy), 32'h0);
        chk("async_done", 32'(bus.done), 32'h0);
        chk("async_result", bus.Result, 32'h0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'd0, 32'd2, 32'd3, 5'd4);
        drain("drain_after_reset");

        for (int i = 0; i < 40; i++) issue(3'($urandom()), pick_operand(), pick_operand(), 5'($urandom()));
        drain("drain_random");
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
